// File: rtl/hole_fill_pkg.sv
// Shared types for the disparity hole filler: token layout, drain FSM states, fill rule.
// HOLE_FILL_AVG_EN selects the rounded-mean two-sided fill instead of min(L,R).
package hole_fill_pkg;

   localparam int unsigned WIDTH   = 16;
   localparam int unsigned FAW     = 6;
   localparam int unsigned MAX_RUN = 60;
   localparam int unsigned LW      = 6;
   localparam int unsigned COL_W   = 11;
   localparam int unsigned IN_W    = WIDTH + 2;
   localparam int unsigned OCC_BIT = WIDTH + 1;
   localparam int unsigned MIS_BIT = WIDTH;
   localparam int unsigned SUM_W   = WIDTH + 1;

   typedef enum logic {
      TOK_VALID = 1'b0,
      TOK_RUN   = 1'b1
   } tok_kind_e;

   // One token per terminating event; a VALID token carries its pixel in tail.
   typedef struct packed {
      tok_kind_e        kind;
      logic [LW-1:0]    len;
      logic [WIDTH-1:0] fill;
      logic             tail_valid;
      logic [WIDTH-1:0] tail;
   } token_t;

   localparam int unsigned TOK_W = $bits(token_t);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_EMIT_RUN  = 2'd1,
      ST_EMIT_TAIL = 2'd2
   } drain_state_e;

   // Two-sided fill prefers the background (smaller disparity) unless averaging is enabled.
   function automatic logic [WIDTH-1:0] fill_value(input logic             has_l,
                                                   input logic [WIDTH-1:0] l,
                                                   input logic             has_r,
                                                   input logic [WIDTH-1:0] r);
      logic [WIDTH-1:0] both;
`ifdef HOLE_FILL_AVG_EN
      logic [WIDTH:0] sum;
      sum  = SUM_W'(l) + SUM_W'(r) + SUM_W'(1);
      both = sum[WIDTH:1];
`else
      both = (l < r) ? l : r;
`endif
      if (has_l && has_r)
         return both;
      else if (has_l)
         return l;
      else if (has_r)
         return r;
      else
         return '0;
   endfunction

endpackage

// File: rtl/disp_hole_fill_if.sv
// Pixel stream bundle: checked disparity in, filled disparity out.
interface disp_hole_fill_if;
   import hole_fill_pkg::*;

   logic [IN_W-1:0]  disp_in;
   logic             valid_in;
   logic [WIDTH-1:0] disp_out;
   logic             filled_out;
   logic             valid_out;

   modport master (
      output disp_in, valid_in,
      input  disp_out, filled_out, valid_out
   );

   modport slave (
      input  disp_in, valid_in,
      output disp_out, filled_out, valid_out
   );

endinterface

// File: rtl/hole_fill_token_fifo.sv
// Single-clock token FIFO; storage is flops and the head entry is always presented on rdata.
module hole_fill_token_fifo #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr,
   input  logic [DW-1:0] wdata,
   input  logic          rd,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty
);

   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned CW    = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          wr_ok;
   logic          rd_ok;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign wr_ok = wr & ~full;
   assign rd_ok = rd & ~empty;
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(wr_ok) - CW'(rd_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/disp_hole_fill.sv
// Replaces occluded/mismatched disparities with a fill from the nearest valid scanline neighbours.
// HOLE_FILL_AVG_EN switches the two-sided fill to the rounded mean of both neighbours.
module disp_hole_fill
   import hole_fill_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clken,
   input  logic [COL_W-1:0] img_width,
   disp_hole_fill_if.slave  bus,
   output logic             ovf_err
);

   // ---------------- run capture ----------------
   logic [COL_W-1:0] col, col_n;
   logic [LW-1:0]    run_len, run_len_n, new_len;
   logic             has_l, has_l_n;
   logic [WIDTH-1:0] last_valid, last_valid_n;
   logic             wr_c;
   token_t           tok_c;
   logic             pix_invalid;
   logic [WIDTH-1:0] pix;
   logic             line_end;

   assign pix_invalid = bus.disp_in[OCC_BIT] | bus.disp_in[MIS_BIT];
   assign pix         = bus.disp_in[WIDTH-1:0];
   assign line_end    = (col == img_width - COL_W'(1));
   assign new_len     = run_len + LW'(1);

   always_comb begin
      col_n        = col;
      run_len_n    = run_len;
      has_l_n      = has_l;
      last_valid_n = last_valid;
      wr_c         = 1'b0;
      tok_c        = '0;
      if (bus.valid_in) begin
         col_n = line_end ? '0 : col + COL_W'(1);
         if (pix_invalid) begin
            // Line end or an over-long run closes the run with only a left neighbour.
            if (line_end || new_len == LW'(MAX_RUN)) begin
               wr_c             = 1'b1;
               tok_c.kind       = TOK_RUN;
               tok_c.len        = new_len;
               tok_c.fill       = fill_value(has_l, last_valid, 1'b0, '0);
               tok_c.tail_valid = 1'b0;
               run_len_n        = '0;
            end else begin
               run_len_n = new_len;
            end
         end else begin
            wr_c             = 1'b1;
            tok_c.tail       = pix;
            tok_c.tail_valid = 1'b1;
            if (run_len != '0) begin
               tok_c.kind = TOK_RUN;
               tok_c.len  = run_len;
               tok_c.fill = fill_value(has_l, last_valid, 1'b1, pix);
            end else begin
               tok_c.kind = TOK_VALID;
            end
            run_len_n    = '0;
            has_l_n      = 1'b1;
            last_valid_n = pix;
         end
         if (line_end) begin
            has_l_n      = 1'b0;
            last_valid_n = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col        <= '0;
         run_len    <= '0;
         has_l      <= 1'b0;
         last_valid <= '0;
      end else if (clken) begin
         col        <= col_n;
         run_len    <= run_len_n;
         has_l      <= has_l_n;
         last_valid <= last_valid_n;
      end
   end

   // ---------------- token FIFO ----------------
   logic             fifo_full, fifo_empty;
   logic [TOK_W-1:0] fifo_rdata;
   logic             pop_c;
   token_t           head;

   assign head = fifo_rdata;

   hole_fill_token_fifo #(
      .DW (TOK_W),
      .AW (FAW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr    (clken & wr_c),
      .wdata (tok_c),
      .rd    (clken & pop_c),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst)
         ovf_err <= 1'b0;
      else if (clken && wr_c && fifo_full)
         ovf_err <= 1'b1;
   end

   // ---------------- drain FSM ----------------
   drain_state_e     state, state_n;
   logic [LW-1:0]    remaining, remaining_n;
   logic [WIDTH-1:0] cur_fill, cur_fill_n;
   logic [WIDTH-1:0] cur_tail, cur_tail_n;
   logic             cur_tv, cur_tv_n;
   logic [WIDTH-1:0] disp_n;
   logic             filled_n;
   logic             valid_n;

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else if (clken)
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty && head.kind == TOK_RUN) begin
               if (head.len != LW'(1))
                  state_n = ST_EMIT_RUN;
               else if (head.tail_valid)
                  state_n = ST_EMIT_TAIL;
            end
         end
         ST_EMIT_RUN: begin
            if (remaining == LW'(1))
               state_n = cur_tv ? ST_EMIT_TAIL : ST_IDLE;
         end
         ST_EMIT_TAIL: state_n = ST_IDLE;
         default:      state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      pop_c       = 1'b0;
      valid_n     = 1'b0;
      disp_n      = bus.disp_out;
      filled_n    = bus.filled_out;
      remaining_n = remaining;
      cur_fill_n  = cur_fill;
      cur_tail_n  = cur_tail;
      cur_tv_n    = cur_tv;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop_c   = 1'b1;
               valid_n = 1'b1;
               if (head.kind == TOK_RUN) begin
                  disp_n      = head.fill;
                  filled_n    = 1'b1;
                  remaining_n = head.len - LW'(1);
                  cur_fill_n  = head.fill;
                  cur_tail_n  = head.tail;
                  cur_tv_n    = head.tail_valid;
               end else begin
                  disp_n   = head.tail;
                  filled_n = 1'b0;
               end
            end
         end
         ST_EMIT_RUN: begin
            valid_n     = 1'b1;
            disp_n      = cur_fill;
            filled_n    = 1'b1;
            remaining_n = remaining - LW'(1);
         end
         ST_EMIT_TAIL: begin
            valid_n  = 1'b1;
            disp_n   = cur_tail;
            filled_n = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         remaining      <= '0;
         cur_fill       <= '0;
         cur_tail       <= '0;
         cur_tv         <= 1'b0;
         bus.disp_out   <= '0;
         bus.filled_out <= 1'b0;
         bus.valid_out  <= 1'b0;
      end else if (clken) begin
         remaining      <= remaining_n;
         cur_fill       <= cur_fill_n;
         cur_tail       <= cur_tail_n;
         cur_tv         <= cur_tv_n;
         bus.disp_out   <= disp_n;
         bus.filled_out <= filled_n;
         bus.valid_out  <= valid_n;
      end
   end

endmodule

// File: doc/disp_hole_fill.md
Name: disp_hole_fill

Overview:
Downstream stage of the window left-right check. Consumes the checked disparity stream (WIDTH data bits plus 2 MSB flags: bit WIDTH+1 occlusion, bit WIDTH mismatch) and replaces every flagged pixel with a value derived from the nearest valid neighbours on the same scanline. Output is a clean WIDTH-bit disparity stream in raster order with a per-pixel "filled" marker, feeding the median/output stage.

Parameters:
WIDTH, 16, disparity width (10 integer + 6 fractional, matches upstream)
FAW, 6, token FIFO address width (depth 2^FAW = 64)
MAX_RUN, 60, maximum invalid run length before forced resolution; must be <= 2^FAW - 4
LW, 6, run-length field width; MAX_RUN < 2^LW

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clken  in  1  global clock enable; low freezes all state
img_width  in  11  pixels per line
disp_in  in  WIDTH+2  checked disparity {occ, mis, disp}
valid_in  in  1  disp_in valid this cycle
disp_out  out  WIDTH  filled disparity
filled_out  out  1  1 = value was synthesised
valid_out  out  1  disp_out valid this cycle
ovf_err  out  1  sticky: token FIFO overflow (must never set)

Behaviour:
- Reset: disp_out=0, filled_out=0, valid_out=0, ovf_err=0; column counter, run state, FIFO pointers, drain state cleared. Reset mid-line discards all buffered pixels; next valid_in is treated as column 0.
- clken=0: no state changes, outputs hold values; valid_in ignored.
- Pixel invalid iff occ|mis. Column counter increments per accepted pixel, wraps to 0 after img_width-1.
- Run capture: last_valid (WIDTH) + has_L, cleared at column 0. Invalid pixel: run_len++ (run opens at 1). Valid pixel with run closed: write VALID token {disp}. Valid pixel with run open: write one RUN token {len, fill, tail=disp}; close run; update last_valid.
- Forced resolution: invalid pixel at column img_width-1, or run_len reaching MAX_RUN -> RUN token with has_R=0, no tail. After MAX_RUN flush, has_L/last_valid retained; a new run starts with the next invalid pixel.
- Fill: has_L&has_R -> min(L,R) (background preference); only one -> that value; neither -> 0.
- At most one FIFO write per cycle; each token carries the terminating valid pixel.
- Drain FSM states IDLE, EMIT_RUN, EMIT_TAIL. IDLE: FIFO non-empty -> pop; VALID token -> output disp, filled=0; RUN token -> output fill, filled=1, load remaining=len-1, next EMIT_RUN (or EMIT_TAIL/IDLE if len=1). EMIT_RUN: one fill pixel per cycle until remaining=0, then EMIT_TAIL if tail present, else IDLE. EMIT_TAIL: output tail, filled=0, -> IDLE (pop allowed same cycle is not required).
- Latency: valid pixel into empty pipeline -> valid_out 2 cycles later. Run of N -> first fill 2 cycles after terminating pixel accepted; N+1 outputs on consecutive cycles.
- Output order equals input raster order; output count per line equals img_width exactly.
- FIFO full on write -> token dropped, ovf_err set sticky (cannot occur for MAX_RUN within bound).

Optional Feature:
HOLE_FILL_AVG_EN: defined -> two-sided fill = (L+R+1)>>1 (rounded mean, WIDTH+1-bit intermediate); undefined -> min(L,R). One-sided and no-neighbour rules unchanged.

Decomposition:
- Package hole_fill_pkg: token type encoding (VALID/RUN), token field widths and packing (type, len LW, fill WIDTH, tail_valid, tail WIDTH), FSM state encoding, flag bit positions (OCC_BIT=WIDTH+1, MIS_BIT=WIDTH).
- Sub-module hole_fill_token_fifo: synchronous single-clock FIFO, depth 2^FAW, full/empty, registered read.

Test Plan:
- All-valid line, img_width=8, disp 1..8 -> same values, filled_out=0, first valid_out 2 cycles after first input, 8 back-to-back outputs.
- Line 10,occ,occ,mis,40 -> 10,10,10,10,40 with filled=0,1,1,1,0; with HOLE_FILL_AVG_EN -> 25,25,25.
- Line start occ,occ,30 -> 30,30,30; line end 20,mis at col img_width-1 -> 20,20 (left-only fill, run flushed at line end).
- Whole line invalid (img_width=16) -> 16 zeros, filled=1; next line's column 0 treated as no left neighbour.
- Run of 70 invalid after valid 50, MAX_RUN=60 -> 60 fills of 50 emitted before run end, remaining 10 filled with min(50, right value); ovf_err stays 0.
- Reset asserted mid-run, clken toggled randomly -> outputs cleared, no stale tokens, count and order preserved across clken gaps.
